// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsu_pkg                                                |
// | Description : Shared types and constants for the load/store unit:    |
// |               FSM state codes, funct3 access encodings, byte-enable  |
// |               base patterns and funct3 decode helpers.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package lsu_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  // funct3 access encodings (size and signedness)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size after funct3 decode
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Byte-enable patterns for lane offset 0
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  // Unlisted funct3 codes (011/110/111) fall through to a word access
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : lsu_align                                              |
// | Description : Combinational lane steering. Builds byte enables and   |
// |               lane-replicated store data, and right-aligns and       |
// |               sign/zero-extends the loaded word.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;

  // Little-endian: the addressed byte moves down to lane 0
  assign w_shift = i_rdata >> {i_offset, 3'b000};

  // Per-size byte enables, store replication and load extension
  always_comb begin
    o_be        = BE_W;
    o_wdata     = i_wdata;
    o_load_data = w_shift;
    case (i_size)
      SZ_B: begin
        o_be        = BE_B << i_offset;
        o_wdata     = {4{i_wdata[7:0]}};
        o_load_data = i_unsigned ? {24'b0, w_shift[7:0]}
                                 : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SZ_H: begin
        o_be        = BE_H << i_offset;
        o_wdata     = {2{i_wdata[15:0]}};
        o_load_data = i_unsigned ? {16'b0, w_shift[15:0]}
                                 : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      default: begin
        o_be        = BE_W;
        o_wdata     = i_wdata;
        o_load_data = w_shift;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : load_store_unit                                        |
// | Description : Multi-cycle data-memory access unit. Accepts one       |
// |               access at a time from the datapath, runs it over a     |
// |               req/gnt/rvalid memory port and returns the extended    |
// |               load value with a single-cycle response pulse.         |
// |               Build option LSU_MISALIGN_CHECK_EN: when defined,      |
// |               misaligned H/W accesses are rejected with misalign_o;  |
// |               when undefined the address is truncated to natural     |
// |               alignment and the access proceeds.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misalign_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_t                r_state;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic                  r_misalign;
  logic [DATA_WIDTH-1:0] r_rdata;

  size_e                 w_in_size;
  logic                  w_misaligned;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic [3:0]            w_be;
  logic [31:0]           w_mem_wdata;
  logic [31:0]           w_load_data;

  assign w_in_size = f3_size(funct3_i);

`ifdef LSU_MISALIGN_CHECK_EN
  // Reject halfwords on odd addresses and words off a 4-byte boundary
  always_comb begin
    w_addr_in    = addr_i;
    w_misaligned = ((w_in_size == SZ_H) && addr_i[0]) ||
                   ((w_in_size == SZ_W) && (addr_i[1:0] != 2'b00));
  end
`else
  // No rejection: drop the offending low address bits instead
  always_comb begin
    w_misaligned = 1'b0;
    w_addr_in    = addr_i;
    case (w_in_size)
      SZ_H:    w_addr_in[0]   = 1'b0;
      SZ_W:    w_addr_in[1:0] = 2'b00;
      default: w_addr_in      = addr_i;
    endcase
  end
`endif

  lsu_align u_align (
    .i_size      (f3_size(r_f3)),
    .i_offset    (r_addr[1:0]),
    .i_unsigned  (f3_unsigned(r_f3)),
    .i_wdata     (r_wdata),
    .i_rdata     (mem_rdata_i),
    .o_be        (w_be),
    .o_wdata     (w_mem_wdata),
    .o_load_data (w_load_data)
  );

  // Request capture, memory handshake sequencing and response registering
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_f3        <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_misalign  <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_misalign  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_we    <= we_i;
            r_f3    <= funct3_i;
            r_addr  <= w_addr_in;
            r_wdata <= wdata_i;
            if (w_misaligned) begin
              // Answer directly; the unit stays ready for the next access
              r_rsp_valid <= 1'b1;
              r_misalign  <= 1'b1;
              r_rdata     <= '0;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mem_rvalid_i) begin
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_we ? '0 : w_load_data;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE);
  assign mem_req_o   = (r_state == ST_REQ);
  assign mem_we_o    = mem_req_o & r_we;
  assign mem_be_o    = mem_req_o ? w_be : 4'b0000;
  assign mem_addr_o  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata_o = w_mem_wdata;
  assign rsp_valid_o = r_rsp_valid;
  assign misalign_o  = r_misalign;
  assign rdata_o     = r_rdata;

endmodule
`default_nettype wire
